// File: rtl/sae_block_feeder.sv
// Streams a current block and NUM_CAND candidate windows into packed 16x16 byte registers
// and tracks the minimum SAE returned by the external SAE processor.
module sae_block_feeder #(
  parameter int NUM_CAND = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [2047:0] o_current_block,
  output logic [2047:0] o_search_window,
  input  logic [15:0]   i_sae_result,
  output logic          o_busy,
  output logic          o_done,
  output logic [15:0]   o_best_sae,
  output logic [7:0]    o_best_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    LOAD_WIN,
    COMPUTE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [7:0] LAST_CAND = 8'(NUM_CAND - 1);

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    cand_q, cand_d;
  logic [15:0]   best_sae_q, best_sae_d;
  logic [7:0]    best_idx_q, best_idx_d;
  logic [2047:0] cur_q, win_q;
  logic          xfer;
  logic          last_byte;

  assign s_ready   = (state_q == LOAD_CUR) || (state_q == LOAD_WIN);
  assign xfer      = s_valid && s_ready;
  assign last_byte = xfer && (byte_q == 8'hFF);

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    cand_d     = cand_q;
    best_sae_d = best_sae_q;
    best_idx_d = best_idx_q;
    if (xfer) begin
      byte_d = byte_q + 8'd1;
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD_CUR;
        end
      end
      LOAD_CUR: begin
        if (last_byte) begin
          state_d = LOAD_WIN;
          cand_d  = 8'd0;
        end
      end
      LOAD_WIN: begin
        if (last_byte) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Strict less-than so a tie keeps the earlier candidate index
        if ((cand_q == 8'd0) || (i_sae_result < best_sae_q)) begin
          best_sae_d = i_sae_result;
          best_idx_d = cand_q;
        end
        if (cand_q == LAST_CAND) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + 8'd1;
          state_d = LOAD_WIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_q     <= 8'd0;
      cand_q     <= 8'd0;
      best_sae_q <= 16'd0;
      best_idx_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      cand_q     <= cand_d;
      best_sae_q <= best_sae_d;
      best_idx_q <= best_idx_d;
    end
  end

  // One write-enabled byte lane per pixel position; the byte counter selects the lane
  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cur_q[gi*8 +: 8] <= 8'd0;
          win_q[gi*8 +: 8] <= 8'd0;
        end else if (xfer && (byte_q == 8'(gi))) begin
          if (state_q == LOAD_CUR) begin
            cur_q[gi*8 +: 8] <= s_data;
          end else begin
            win_q[gi*8 +: 8] <= s_data;
          end
        end
      end
    end
  endgenerate

  assign o_current_block = cur_q;
  assign o_search_window = win_q;
  assign o_busy          = (state_q != IDLE);
  assign o_done          = (state_q == DONE);
  assign o_best_sae      = best_sae_q;
  assign o_best_idx      = best_idx_q;

endmodule
